fetch_pc_gen: RTL and testbench
===============================

// Module: fetch_pc_gen
// PURPOSE
//  2-wide fetch stage, directly upstream of the gshare BHT and downstream to decode.
//  Owns the PC, presents an aligned 8-byte fetch block to the I-cache and to the BHT,
//  and picks the next PC from BHT taken predictions and decoded branch displacements.
//  Registers up to two instructions per cycle into the IF/ID latch; redirects on ROB mispredict.
// PARAMETERS
//  RESET_PC   64'h0   PC loaded on reset
// PORTS
//  clock              in   1   system clock
//  reset              in   1   synchronous, active-high reset
//  icache_data        in   64  fetch block at if_pc: [31:0] = slot0, [63:32] = slot1
//  icache_valid       in   1   icache_data valid this cycle
//  bht_taken0         in   1   BHT prediction for slot0
//  bht_taken1         in   1   BHT prediction for slot1
//  id_stall           in   1   decode cannot accept; hold IF/ID latch
//  rob_mis_pred       in   1   mispredict redirect from ROB
//  rob_target_pc      in   64  correct PC on rob_mis_pred
//  if_pc              out  64  {pc[63:3],3'b0}; to I-cache and BHT
//  if_valid_inst0     out  1   slot0 valid to BHT (gated, see below)
//  if_valid_inst1     out  1   slot1 valid to BHT
//  if_IR0 / if_IR1    out  32  raw slot instructions to BHT
//  if_id_valid0/1     out  1   IF/ID latch slot valid
//  if_id_IR0/1        out  32  IF/ID latch instructions
//  if_id_NPC0/1       out  64  slot PC + 4
//  if_id_pred_taken0/1 out 1   predicted direction stored with slot
//  if_id_pred_target0/1 out 64 predicted next PC for the slot
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=FETCH, all if_id_* = 0.
//  States: FETCH, REDIRECT, HALTED.
//   FETCH->REDIRECT on rob_mis_pred; REDIRECT->FETCH after exactly 1 cycle (bubble, no latch)
//   unless rob_mis_pred again (stays REDIRECT, reloads pc). FETCH->HALTED when an accepted
//   slot is HALT (32'h0000_0555); HALTED->REDIRECT only on rob_mis_pred.
//  Slot PCs: pc0={pc[63:3],3'b000}, pc1=pc0+4. Slot0 live iff pc[2]==0; slot1 always live.
//  Branch decode: cond = IR[31:29] in {6,7} and opcode not BR(0x30)/BSR(0x34);
//   uncond = BR/BSR (always taken). JMP-class (0x1A) predicted not-taken.
//  Target = slotPC + 4 + (sext(IR[20:0]) << 2), 64-bit, wraps modulo 2^64.
//  taken_k = live_k & (uncond_k | (cond_k & bht_taken_k)).
//  fire = state==FETCH & icache_valid & ~id_stall & ~rob_mis_pred.
//  if_valid_inst0 = fire & live0; if_valid_inst1 = fire & ~(live0 & taken0)
//   -> BHT history advances only once per accepted block; zero on stall.
//  On fire: latch slot0 (valid=live0), slot1 (valid unless slot0 taken or slot0 HALT);
//   next pc = target0 if taken0, else target1 if slot1 taken, else pc0+8.
//  Stall (icache_valid=0 or id_stall=1): pc and IF/ID latch hold; icache_valid=0 with
//   id_stall=0 clears if_id_valid* (bubble to decode).
//  rob_mis_pred (highest priority, any state): pc<=rob_target_pc, if_id_valid*<=0 next edge.
//  Reset in any state overrides everything, same cycle.
// TESTING
//  Reset, RESET_PC=0, icache_valid=1, no branches -> pc 0,8,16; both slots valid each cycle.
//  Slot0=BEQ disp=+3 at pc 0x100, bht_taken0=1 -> slot1 invalid, next pc=0x110, if_valid_inst1=0.
//  pc=0x104 (slot0 dead), slot1 BR disp=-2 -> only slot1 latched, next pc=0x100.
//  id_stall=1 for 3 cycles -> pc/latch frozen, if_valid_inst0/1=0 all 3 cycles.
//  rob_mis_pred with target 0x2000 while id_stall=1 -> latch cleared, 1 bubble, fetch at 0x2000.
//  HALT in slot0 -> slot1 dropped, HALTED, no fetch until rob_mis_pred.

Source files
------------

// File: rtl/fetch_pc_gen_if.sv
// Interface bundling the fetch-stage bus: I-cache, BHT, decode stall, ROB redirect and IF/ID latch.
interface fetch_pc_gen_if;
  logic [63:0] icache_data;
  logic        icache_valid;
  logic        bht_taken0;
  logic        bht_taken1;
  logic        id_stall;
  logic        rob_mis_pred;
  logic [63:0] rob_target_pc;

  logic [63:0] if_pc;
  logic        if_valid_inst0;
  logic        if_valid_inst1;
  logic [31:0] if_IR0;
  logic [31:0] if_IR1;
  logic        if_id_valid0;
  logic        if_id_valid1;
  logic [31:0] if_id_IR0;
  logic [31:0] if_id_IR1;
  logic [63:0] if_id_NPC0;
  logic [63:0] if_id_NPC1;
  logic        if_id_pred_taken0;
  logic        if_id_pred_taken1;
  logic [63:0] if_id_pred_target0;
  logic [63:0] if_id_pred_target1;

  modport master (
    input  icache_data, icache_valid, bht_taken0, bht_taken1,
           id_stall, rob_mis_pred, rob_target_pc,
    output if_pc, if_valid_inst0, if_valid_inst1, if_IR0, if_IR1,
           if_id_valid0, if_id_valid1, if_id_IR0, if_id_IR1,
           if_id_NPC0, if_id_NPC1, if_id_pred_taken0, if_id_pred_taken1,
           if_id_pred_target0, if_id_pred_target1
  );

  modport slave (
    output icache_data, icache_valid, bht_taken0, bht_taken1,
           id_stall, rob_mis_pred, rob_target_pc,
    input  if_pc, if_valid_inst0, if_valid_inst1, if_IR0, if_IR1,
           if_id_valid0, if_id_valid1, if_id_IR0, if_id_IR1,
           if_id_NPC0, if_id_NPC1, if_id_pred_taken0, if_id_pred_taken1,
           if_id_pred_target0, if_id_pred_target1
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// 2-wide fetch stage: owns the PC, predicts next PC from BHT/branch decode, fills IF/ID latch.
//
// state      | meaning
// S_FETCH    | fetching and latching blocks when I-cache data and decode allow
// S_REDIRECT | one bubble cycle after a ROB redirect; nothing latched
// S_HALTED   | HALT accepted; no fetch until the next ROB redirect
module fetch_pc_gen #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input logic           clock,
  input logic           reset,
  fetch_pc_gen_if.master bus
);
  localparam logic [31:0] HALT_IR = 32'h0000_0555;

  typedef enum logic [1:0] {S_FETCH, S_REDIRECT, S_HALTED} state_t;

  state_t      state;
  logic [63:0] pc;
  logic [63:0] pc0;
  logic [63:0] pc1;
  logic [31:0] ir0;
  logic [31:0] ir1;
  logic        live0;
  logic        taken0;
  logic        taken1;
  logic        halt0;
  logic        halt1;
  logic        keep1;
  logic        fire;
  logic [63:0] target0;
  logic [63:0] target1;
  logic [63:0] next_pc;

  function automatic logic is_uncond(input logic [31:0] ir);
    return (ir[31:26] == 6'h30) || (ir[31:26] == 6'h34);
  endfunction

  function automatic logic is_cond(input logic [31:0] ir);
    return ((ir[31:29] == 3'd6) || (ir[31:29] == 3'd7)) && !is_uncond(ir);
  endfunction

  function automatic logic [63:0] br_target(input logic [63:0] slot_pc, input logic [31:0] ir);
    return slot_pc + 64'd4 + {{41{ir[20]}}, ir[20:0], 2'b00};
  endfunction

  assign pc0     = {pc[63:3], 3'b000};
  assign pc1     = pc0 + 64'd4;
  assign ir0     = bus.icache_data[31:0];
  assign ir1     = bus.icache_data[63:32];
  assign live0   = ~pc[2];
  assign target0 = br_target(pc0, ir0);
  assign target1 = br_target(pc1, ir1);
  assign taken0  = live0 & (is_uncond(ir0) | (is_cond(ir0) & bus.bht_taken0));
  assign taken1  = is_uncond(ir1) | (is_cond(ir1) & bus.bht_taken1);
  assign halt0   = live0 & (ir0 == HALT_IR);
  assign halt1   = (ir1 == HALT_IR);
  assign keep1   = ~taken0 & ~halt0;
  assign fire    = (state == S_FETCH) & bus.icache_valid & ~bus.id_stall & ~bus.rob_mis_pred;

  always_comb begin
    next_pc = pc0 + 64'd8;
    if (taken0)
      next_pc = target0;
    else if (taken1)
      next_pc = target1;
  end

  // BHT sees slot1 unless a taken slot0 redirects around it; history moves once per block
  assign bus.if_pc          = pc0;
  assign bus.if_valid_inst0 = fire & live0;
  assign bus.if_valid_inst1 = fire & ~(live0 & taken0);
  assign bus.if_IR0         = ir0;
  assign bus.if_IR1         = ir1;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc                     <= RESET_PC;
      state                  <= S_FETCH;
      bus.if_id_valid0       <= 1'b0;
      bus.if_id_valid1       <= 1'b0;
      bus.if_id_IR0          <= '0;
      bus.if_id_IR1          <= '0;
      bus.if_id_NPC0         <= '0;
      bus.if_id_NPC1         <= '0;
      bus.if_id_pred_taken0  <= 1'b0;
      bus.if_id_pred_taken1  <= 1'b0;
      bus.if_id_pred_target0 <= '0;
      bus.if_id_pred_target1 <= '0;
    end else if (bus.rob_mis_pred) begin
      pc               <= bus.rob_target_pc;
      state            <= S_REDIRECT;
      bus.if_id_valid0 <= 1'b0;
      bus.if_id_valid1 <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (fire) begin
            pc                     <= next_pc;
            bus.if_id_valid0       <= live0;
            bus.if_id_valid1       <= keep1;
            bus.if_id_IR0          <= ir0;
            bus.if_id_IR1          <= ir1;
            bus.if_id_NPC0         <= pc0 + 64'd4;
            bus.if_id_NPC1         <= pc1 + 64'd4;
            bus.if_id_pred_taken0  <= taken0;
            bus.if_id_pred_taken1  <= taken1;
            bus.if_id_pred_target0 <= taken0 ? target0 : pc0 + 64'd4;
            bus.if_id_pred_target1 <= taken1 ? target1 : pc1 + 64'd4;
            if (halt0 | (keep1 & halt1))
              state <= S_HALTED;
          end else if (!bus.id_stall) begin
            bus.if_id_valid0 <= 1'b0;
            bus.if_id_valid1 <= 1'b0;
          end
        end
        S_REDIRECT: begin
          state <= S_FETCH;
          if (!bus.id_stall) begin
            bus.if_id_valid0 <= 1'b0;
            bus.if_id_valid1 <= 1'b0;
          end
        end
        S_HALTED: begin
          if (!bus.id_stall) begin
            bus.if_id_valid0 <= 1'b0;
            bus.if_id_valid1 <= 1'b0;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: sequential fetch, branch prediction, stalls, redirect, HALT.
module tb_fetch_pc_gen;
  localparam logic [31:0] NOP  = 32'h47FF_041F;
  localparam logic [31:0] HALT = 32'h0000_0555;
  localparam logic [31:0] BEQ3 = 32'hE400_0003;  // BEQ r0, +3
  localparam logic [31:0] BRM2 = 32'hC01F_FFFE;  // BR  r0, -2
  localparam logic [31:0] BNE1 = 32'hF400_0001;  // BNE r0, +1

  logic clock;
  logic reset;
  int   n_vec;
  int   n_err;

  fetch_pc_gen_if bus ();

  fetch_pc_gen #(.RESET_PC(64'h0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] s1, input logic [31:0] s0,
                       input logic b0, input logic b1, input logic stall);
    bus.icache_valid = iv;
    bus.icache_data  = {s1, s0};
    bus.bht_taken0   = b0;
    bus.bht_taken1   = b1;
    bus.id_stall     = stall;
    #1;
  endtask

  task automatic redirect(input logic [63:0] tgt);
    bus.rob_mis_pred  = 1'b1;
    bus.rob_target_pc = tgt;
    step();
    bus.rob_mis_pred  = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.rob_mis_pred  = 1'b0;
    bus.rob_target_pc = '0;
    drive(1'b0, NOP, NOP, 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk("rst_pc", bus.if_pc, 64'h0);
    chk("rst_v0", 64'(bus.if_id_valid0), 64'd0);
    chk("rst_v1", 64'(bus.if_id_valid1), 64'd0);
    chk("rst_npc0", bus.if_id_NPC0, 64'h0);
    reset = 1'b0;

    // straight-line fetch
    drive(1'b1, NOP, NOP, 1'b0, 1'b0, 1'b0);
    chk("seq_vi0", 64'(bus.if_valid_inst0), 64'd1);
    chk("seq_vi1", 64'(bus.if_valid_inst1), 64'd1);
    step();
    chk("seq_pc8", bus.if_pc, 64'h8);
    chk("seq_v0", 64'(bus.if_id_valid0), 64'd1);
    chk("seq_v1", 64'(bus.if_id_valid1), 64'd1);
    chk("seq_npc1", bus.if_id_NPC1, 64'h8);
    step();
    chk("seq_pc16", bus.if_pc, 64'h10);
    chk("seq_npc0b", bus.if_id_NPC0, 64'hC);

    // slot0 BEQ taken at 0x100
    redirect(64'h100);
    drive(1'b1, NOP, BEQ3, 1'b1, 1'b0, 1'b0);
    chk("rd_bubble_vi0", 64'(bus.if_valid_inst0), 64'd0);
    step();
    chk("rd_v0", 64'(bus.if_id_valid0), 64'd0);
    chk("beq_vi0", 64'(bus.if_valid_inst0), 64'd1);
    chk("beq_vi1", 64'(bus.if_valid_inst1), 64'd0);
    step();
    chk("beq_pc", bus.if_pc, 64'h110);
    chk("beq_v0", 64'(bus.if_id_valid0), 64'd1);
    chk("beq_v1", 64'(bus.if_id_valid1), 64'd0);
    chk("beq_pt0", 64'(bus.if_id_pred_taken0), 64'd1);
    chk("beq_tgt0", bus.if_id_pred_target0, 64'h110);

    // pc=0x104: slot0 dead, slot1 BR -2
    redirect(64'h104);
    drive(1'b1, BRM2, NOP, 1'b0, 1'b0, 1'b0);
    step();
    chk("dead_ifpc", bus.if_pc, 64'h100);
    chk("dead_vi0", 64'(bus.if_valid_inst0), 64'd0);
    chk("dead_vi1", 64'(bus.if_valid_inst1), 64'd1);
    step();
    chk("br_v0", 64'(bus.if_id_valid0), 64'd0);
    chk("br_v1", 64'(bus.if_id_valid1), 64'd1);
    chk("br_pt1", 64'(bus.if_id_pred_taken1), 64'd1);
    chk("br_tgt1", bus.if_id_pred_target1, 64'h100);
    chk("br_npc1", bus.if_id_NPC1, 64'h108);
    chk("br_pc", bus.if_pc, 64'h100);

    // decode stall for 3 cycles
    drive(1'b1, NOP, NOP, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_vi0", 64'(bus.if_valid_inst0), 64'd0);
      chk("stall_vi1", 64'(bus.if_valid_inst1), 64'd0);
      step();
      chk("stall_pc", bus.if_pc, 64'h100);
      chk("stall_v1", 64'(bus.if_id_valid1), 64'd1);
      chk("stall_ir1", 64'(bus.if_id_IR1), 64'(BRM2));
    end

    // mispredict while stalled
    redirect(64'h2000);
    chk("mp_v0", 64'(bus.if_id_valid0), 64'd0);
    chk("mp_v1", 64'(bus.if_id_valid1), 64'd0);
    chk("mp_pc", bus.if_pc, 64'h2000);
    drive(1'b1, NOP, NOP, 1'b0, 1'b0, 1'b0);
    chk("mp_bubble_vi0", 64'(bus.if_valid_inst0), 64'd0);
    step();
    chk("mp_bubble_v0", 64'(bus.if_id_valid0), 64'd0);
    chk("mp_fetch_vi0", 64'(bus.if_valid_inst0), 64'd1);
    step();
    chk("mp_fetch_v0", 64'(bus.if_id_valid0), 64'd1);
    chk("mp_npc0", bus.if_id_NPC0, 64'h2004);
    chk("mp_pc2", bus.if_pc, 64'h2008);

    // I-cache miss bubbles decode
    drive(1'b0, NOP, NOP, 1'b0, 1'b0, 1'b0);
    step();
    chk("miss_v0", 64'(bus.if_id_valid0), 64'd0);
    chk("miss_pc", bus.if_pc, 64'h2008);

    // HALT in slot0
    drive(1'b1, NOP, HALT, 1'b0, 1'b0, 1'b0);
    step();
    chk("halt_v0", 64'(bus.if_id_valid0), 64'd1);
    chk("halt_ir0", 64'(bus.if_id_IR0), 64'(HALT));
    chk("halt_v1", 64'(bus.if_id_valid1), 64'd0);
    chk("halt_vi0", 64'(bus.if_valid_inst0), 64'd0);
    step();
    step();
    chk("halted_vi0", 64'(bus.if_valid_inst0), 64'd0);
    chk("halted_v0", 64'(bus.if_id_valid0), 64'd0);
    chk("halted_pc", bus.if_pc, 64'h2010);

    // leave HALTED; slot1 BNE taken at 0x3004
    redirect(64'h3000);
    drive(1'b1, BNE1, NOP, 1'b0, 1'b1, 1'b0);
    step();
    chk("bne_vi0", 64'(bus.if_valid_inst0), 64'd1);
    chk("bne_vi1", 64'(bus.if_valid_inst1), 64'd1);
    step();
    chk("bne_v0", 64'(bus.if_id_valid0), 64'd1);
    chk("bne_v1", 64'(bus.if_id_valid1), 64'd1);
    chk("bne_pt1", 64'(bus.if_id_pred_taken1), 64'd1);
    chk("bne_tgt1", bus.if_id_pred_target1, 64'h300C);
    chk("bne_pc", bus.if_pc, 64'h3008);
    chk("bne_dead_vi0", 64'(bus.if_valid_inst0), 64'd0);

    // reset mid-run
    reset = 1'b1;
    step();
    chk("rst2_pc", bus.if_pc, 64'h0);
    chk("rst2_v1", 64'(bus.if_id_valid1), 64'd0);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
